// File: rtl/plab4_net_tp_pkg.sv
// plab4_net_tp_pkg: shared constants and domain-select type for the time-partitioned ring.
package plab4_net_tp_pkg;

    localparam int unsigned c_num_domains = 2;
    localparam int unsigned c_cnt_nbits   = 8;
    localparam int unsigned c_def_slot    = 8;
    localparam int unsigned c_def_dead    = 2;

    typedef logic [c_cnt_nbits-1:0] cnt_t;

    typedef enum logic {
        DOMAIN_0 = 1'b0,
        DOMAIN_1 = 1'b1
    } domain_t;

endpackage

// File: rtl/plab4_net_tp_domain_sched_if.sv
// plab4_net_tp_domain_sched_if: config handshake and schedule outputs of the TP domain scheduler.
interface plab4_net_tp_domain_sched_if;
    import plab4_net_tp_pkg::*;

    logic    cfg_val;
    logic    cfg_rdy;
    cnt_t    cfg_slot;
    cnt_t    cfg_dead;
    logic    cfg_err;
    domain_t domain;
    logic    inject_en;
    logic    slot_start;

    modport master (
        output cfg_val, cfg_slot, cfg_dead,
        input  cfg_rdy, cfg_err, domain, inject_en, slot_start
    );

    modport slave (
        input  cfg_val, cfg_slot, cfg_dead,
        output cfg_rdy, cfg_err, domain, inject_en, slot_start
    );

endinterface

// File: rtl/plab4_net_tp_slot_counter.sv
// plab4_net_tp_slot_counter: per-slot cycle counter and domain toggle.
module plab4_net_tp_slot_counter
    import plab4_net_tp_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  cnt_t    slot_len,
    input  cnt_t    dead_len,
    output domain_t domain,
    output logic    slot_start,
    output logic    wrap,
    output logic    round_wrap,
    output logic    inject_en
);

    cnt_t    cnt_q;
    domain_t domain_q;

    always_comb begin
        wrap       = cnt_q == slot_len - cnt_t'(1);
        round_wrap = wrap && domain_q == DOMAIN_1;
        inject_en  = cnt_q < slot_len - dead_len;
        slot_start = cnt_q == '0;
        domain     = domain_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            domain_q <= DOMAIN_0;
        end else if (wrap) begin
            cnt_q    <= '0;
            domain_q <= domain_q == DOMAIN_0 ? DOMAIN_1 : DOMAIN_0;
        end else begin
            cnt_q    <= cnt_q + cnt_t'(1);
        end
    end

endmodule

// File: rtl/plab4_net_tp_domain_sched.sv
// plab4_net_tp_domain_sched: fixed time-partitioned domain schedule with drain window per slot.
// Runtime slot/dead reconfiguration is built only when PLAB4_NET_TP_SCHED_CFG_EN is defined.
module plab4_net_tp_domain_sched
    import plab4_net_tp_pkg::*;
#(
    parameter int unsigned p_slot_cycles = c_def_slot,
    parameter int unsigned p_dead_cycles = c_def_dead
)
(
    input  logic                         clk,
    input  logic                         reset,
    plab4_net_tp_domain_sched_if.slave   sched
);

    cnt_t slot_q;
    cnt_t dead_q;
    logic wrap;
    logic round_wrap;

    plab4_net_tp_slot_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .slot_len   (slot_q),
        .dead_len   (dead_q),
        .domain     (sched.domain),
        .slot_start (sched.slot_start),
        .wrap       (wrap),
        .round_wrap (round_wrap),
        .inject_en  (sched.inject_en)
    );

`ifdef PLAB4_NET_TP_SCHED_CFG_EN
    logic pend_val_q;
    cnt_t pend_slot_q;
    cnt_t pend_dead_q;
    logic cfg_err_q;
    logic accept;
    logic legal;
    logic unused_wrap;

    always_comb begin
        accept        = sched.cfg_val && !pend_val_q;
        legal         = sched.cfg_slot >= cnt_t'(2) && sched.cfg_dead < sched.cfg_slot;
        sched.cfg_rdy = !pend_val_q;
        sched.cfg_err = cfg_err_q;
        unused_wrap   = wrap;
    end

    // New lengths only land on a round boundary so both domains always see equal slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= cnt_t'(p_slot_cycles);
            dead_q      <= cnt_t'(p_dead_cycles);
            pend_val_q  <= 1'b0;
            pend_slot_q <= '0;
            pend_dead_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= accept && !legal;
            if (round_wrap && pend_val_q) begin
                slot_q <= pend_slot_q;
                dead_q <= pend_dead_q;
            end
            if (accept && legal) begin
                pend_val_q  <= 1'b1;
                pend_slot_q <= sched.cfg_slot;
                pend_dead_q <= sched.cfg_dead;
            end else if (round_wrap) begin
                pend_val_q  <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    always_comb begin
        slot_q        = cnt_t'(p_slot_cycles);
        dead_q        = cnt_t'(p_dead_cycles);
        sched.cfg_rdy = 1'b0;
        sched.cfg_err = 1'b0;
        unused_cfg    = ^{sched.cfg_val, sched.cfg_slot, sched.cfg_dead, wrap, round_wrap};
    end
`endif

endmodule

// File: tb/tb_plab4_net_tp_domain_sched.sv
// tb_plab4_net_tp_domain_sched: directed plus random stimulus against a round-level schedule model.
`timescale 1ns/1ps
module tb_plab4_net_tp_domain_sched;
    import plab4_net_tp_pkg::*;

    localparam int P_SLOT = 8;
    localparam int P_DEAD = 2;
`ifdef PLAB4_NET_TP_SCHED_CFG_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    plab4_net_tp_domain_sched_if bus ();

    plab4_net_tp_domain_sched #(
        .p_slot_cycles (P_SLOT),
        .p_dead_cycles (P_DEAD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sched (bus)
    );

    always #5 clk = ~clk;

    // Model: position inside the current two-slot round plus active/pending lengths.
    int m_t, m_slot, m_dead, m_pslot, m_pdead;
    bit m_pend, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_slot = P_SLOT; m_dead = P_DEAD; m_pend = 0; m_err = 0;
        m_pslot = 0; m_pdead = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input int s, input int d);
        bit acc, legal;
        if (r) begin
            model_reset();
            return;
        end
        acc   = CFG_EN && v && !m_pend;
        legal = s >= 2 && d < s;
        m_err = acc && !legal;
        if (m_t == 2 * m_slot - 1) begin
            m_t = 0;
            if (m_pend) begin
                m_slot = m_pslot; m_dead = m_pdead; m_pend = 0;
            end
        end else begin
            m_t++;
        end
        if (acc && legal) begin
            m_pend = 1; m_pslot = s; m_pdead = d;
        end
    endtask

    task automatic compare_all();
        int pos;
        pos = m_t % m_slot;
        check("domain",     32'(bus.domain),     32'(m_t >= m_slot));
        check("slot_start", 32'(bus.slot_start), 32'(pos == 0));
        check("inject_en",  32'(bus.inject_en),  32'(pos < m_slot - m_dead));
        check("cfg_rdy",    32'(bus.cfg_rdy),    32'(CFG_EN && !m_pend));
        check("cfg_err",    32'(bus.cfg_err),    32'(m_err));
    endtask

    task automatic cycle(input bit r, input bit v, input int s, input int d);
        compare_all();
        reset        = r;
        bus.cfg_val  = v;
        bus.cfg_slot = cnt_t'(s);
        bus.cfg_dead = cnt_t'(d);
        model_step(r, v, s, d);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; bus.cfg_val = 1'b0; bus.cfg_slot = '0; bus.cfg_dead = '0;
        repeat (2) @(negedge clk);
        model_reset();
        check("rst_slot_start", 32'(bus.slot_start), 32'd1);
        check("rst_inject_en",  32'(bus.inject_en),  32'd1);
        check("rst_domain",     32'(bus.domain),     32'd0);
        for (int t = 0; t < 90; t++) begin
            if (t == 6)  check("c6_inject_off", 32'(bus.inject_en), 32'd0);
            if (t == 8)  check("c8_domain1",    32'(bus.domain), 32'd1);
            if (t == 16) check("c16_slot_start", 32'(bus.slot_start), 32'd1);
            case (t)
                3:       cycle(0, 1, 4, 1);
                30:      cycle(0, 1, 4, 4);
                32:      cycle(0, 1, 1, 0);
                40:      cycle(0, 1, 6, 0);
                default: cycle(0, 0, 0, 0);
            endcase
        end
        // Mid-round reset with a write that would otherwise be pending.
        cycle(0, 1, 5, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("midrst_slot_start", 32'(bus.slot_start), 32'd1);
        check("midrst_domain",     32'(bus.domain),     32'd0);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
        compare_all();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
